// File: rtl/sram_controller.sv
// Sequences one 32-bit MEM-stage load/store onto a 16-bit asynchronous SRAM as two
// half-word transfers (low, then high), holding ready low so the pipeline stalls.
module sram_controller #(
    parameter int N           = 32,
    parameter int WAIT_CYCLES = 2,
    parameter int BASE_ADDR   = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic         rd_en,
    input  logic [N-1:0] address,
    input  logic [N-1:0] writeData,
    output logic [N-1:0] readData,
    output logic         ready,
    inout  wire  [15:0]  SRAM_DQ,
    output logic [17:0]  SRAM_ADDR,
    output logic         SRAM_WE_N,
    output logic         SRAM_OE_N,
    output logic         SRAM_CE_N,
    output logic         SRAM_UB_N,
    output logic         SRAM_LB_N
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic            r_op_wr;
    logic [16:0]     r_word;
    logic [N-1:0]    r_wdata;
    logic [N-1:0]    r_rdata;
    logic [17:0]     r_sram_addr;

    logic            w_req;
    logic            w_last;
    logic            w_active;
    logic            w_ready;
    logic            w_drive;
    logic [15:0]     w_dq_out;
    logic [N-1:0]    w_offset;
    logic [16:0]     w_word;
    logic            w_unused;

    // Word index wraps modulo 2^17; the byte offset and upper bits are dropped.
    assign w_offset = address - N'(BASE_ADDR);
    assign w_word   = w_offset[18:2];
    assign w_unused = ^{w_offset[N-1:19], w_offset[1:0]};

    assign w_req  = wr_en | rd_en;
    assign w_last = (r_cnt == CW'(WAIT_CYCLES - 1));

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_active     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = !w_req;
                if (w_req) w_state_next = S_LOW;
            end
            S_LOW: begin
                w_active = 1'b1;
                if (w_last) w_state_next = S_HIGH;
            end
            S_HIGH: begin
                w_active = 1'b1;
                if (w_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                w_ready      = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_op_wr     <= 1'b0;
            r_word      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_sram_addr <= '0;
        end else begin
            if ((r_state == S_LOW) || (r_state == S_HIGH))
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            else
                r_cnt <= '0;

            if ((r_state == S_IDLE) && w_req) begin
                r_op_wr     <= wr_en;
                r_word      <= w_word;
                r_wdata     <= writeData;
                r_sram_addr <= {w_word, 1'b0};
            end

            // Read halves are sampled on the final cycle of each transfer window.
            if ((r_state == S_LOW) && w_last) begin
                r_sram_addr <= {r_word, 1'b1};
                if (!r_op_wr) r_rdata[15:0] <= SRAM_DQ;
            end

            if ((r_state == S_HIGH) && w_last && !r_op_wr)
                r_rdata[31:16] <= SRAM_DQ;
        end
    end

    assign w_drive  = w_active && r_op_wr;
    assign w_dq_out = (r_state == S_HIGH) ? r_wdata[31:16] : r_wdata[15:0];
    assign SRAM_DQ  = w_drive ? w_dq_out : 16'hzzzz;

    assign SRAM_WE_N = !(w_active && r_op_wr);
    assign SRAM_OE_N = !(w_active && !r_op_wr);
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_ADDR = r_sram_addr;
    assign readData  = r_rdata;
    assign ready     = w_ready;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: behavioural async SRAM, read scoreboard queue,
// and immediate-assertion checks on handshake, bus control and data.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    wire  [31:0] read_data;
    wire         ready;
    wire  [15:0] sram_dq;
    wire  [17:0] sram_addr;
    wire         we_n, oe_n, ce_n, ub_n, lb_n;

    logic [15:0] mem [0:63];
    logic        probe_en = 1'b0;
    logic [31:0] shadow [int];
    logic [31:0] exp_q [$];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    sram_controller #(.N(32), .WAIT_CYCLES(2), .BASE_ADDR(1024)) dut (
        .clk(clk), .rst(rst_n), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .writeData(write_data), .readData(read_data), .ready(ready),
        .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n),
        .SRAM_CE_N(ce_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
    );

    // SRAM drives on OE_N; a probe driver pulls the bus to 0 when the DUT must be released.
    assign sram_dq = (!oe_n) ? mem[sram_addr[5:0]] : 16'hzzzz;
    assign sram_dq = probe_en ? 16'h0000 : 16'hzzzz;

    always @(posedge clk) begin
        if (!we_n) mem[sram_addr[5:0]] <= sram_dq;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input logic garble);
        logic [31:0] off;
        logic [17:0] exp_lo;
        logic [31:0] rd_before;
        int          low_cnt;
        int          we_cnt;
        int          oe_cnt;
        off     = a - 32'd1024;
        exp_lo  = {off[18:2], 1'b0};
        low_cnt = 0;
        we_cnt  = 0;
        oe_cnt  = 0;
        @(negedge clk);
        rd_before  = read_data;
        wr_en      = w;
        rd_en      = r;
        address    = a;
        write_data = d;
        if (w) shadow[a] = d;
        else   exp_q.push_back(shadow[a]);
        #1 check("req_ready_low", {31'd0, ready}, 32'd0);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        if (garble) begin
            address    = 32'd2000;
            write_data = ~d;
        end
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (ready) break;
            low_cnt++;
            if (!we_n) we_cnt++;
            if (!oe_n) oe_cnt++;
            if (low_cnt == 1) check("addr_low", {14'd0, sram_addr}, {14'd0, exp_lo});
            if (low_cnt == 4) check("addr_high", {14'd0, sram_addr}, {14'd0, exp_lo | 18'd1});
        end
        check("done_ready", {31'd0, ready}, 32'd1);
        check("busy_cycles", low_cnt, 4);
        check("we_cycles", we_cnt, w ? 4 : 0);
        check("oe_cycles", oe_cnt, w ? 0 : 4);
        if (w) begin
            check("rdata_kept", read_data, rd_before);
        end else if (exp_q.size() > 0) begin
            check("read_data", read_data, exp_q.pop_front());
        end else begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end
        $display("txn %s addr=%0d wdata=0x%08h rdata=0x%08h busy=%0d",
                 w ? "WR" : "RD", a, d, read_data, low_cnt);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        probe_en = 1'b1;
        rst_n    = 1'b1;
        #1;
        check("idle_ready", {31'd0, ready}, 32'd1);
        check("idle_we_n", {31'd0, we_n}, 32'd1);
        check("idle_oe_n", {31'd0, oe_n}, 32'd1);
        check("idle_dq_released", {16'd0, sram_dq}, 32'd0);
        check("idle_read_data", read_data, 32'd0);
        check("ctrl_low", {29'd0, ce_n, ub_n, lb_n}, 32'd0);
        @(negedge clk);
        probe_en = 1'b0;

        access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 1'b0);
        check("mem_half2", {16'd0, mem[2]}, 32'h0000BEEF);
        check("mem_half3", {16'd0, mem[3]}, 32'h0000DEAD);
        @(negedge clk);
        access(1'b0, 1'b1, 32'd1028, 32'd0, 1'b0);
        @(negedge clk);

        // Both enables set: write wins; the read that follows is back-to-back.
        access(1'b1, 1'b1, 32'd1032, 32'h12345678, 1'b0);
        access(1'b0, 1'b1, 32'd1032, 32'd0, 1'b0);
        check("mem_half4", {16'd0, mem[4]}, 32'h00005678);
        check("mem_half5", {16'd0, mem[5]}, 32'h00001234);

        access(1'b0, 1'b1, 32'd1032, 32'd0, 1'b1);
        access(1'b1, 1'b0, 32'd1036, 32'hCAFEF00D, 1'b1);
        access(1'b0, 1'b1, 32'd1036, 32'd0, 1'b0);
        access(1'b0, 1'b1, 32'd1028, 32'd0, 1'b0);

        // Reset asserted while the high half of a write is on the bus.
        @(negedge clk);
        wr_en      = 1'b1;
        address    = 32'd1040;
        write_data = 32'hA5A5_5A5A;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("pre_reset_we_low", {31'd0, we_n}, 32'd0);
        rst_n    = 1'b0;
        probe_en = 1'b1;
        #1;
        check("rst_we_n", {31'd0, we_n}, 32'd1);
        check("rst_oe_n", {31'd0, oe_n}, 32'd1);
        check("rst_dq_released", {16'd0, sram_dq}, 32'd0);
        check("rst_read_data", read_data, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd1);
        @(negedge clk);
        rst_n    = 1'b1;
        probe_en = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_ready", {31'd0, ready}, 32'd1);
        check("post_rst_we_n", {31'd0, we_n}, 32'd1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
